// File: rtl/timer_pkg.sv
// timer_pkg: shared widths, clock-select encodings and TCR bit positions for the 8-bit timer
package timer_pkg;
   localparam int CNT_W = 8;
   localparam int DIV_W = 4;
   typedef enum logic [1:0] {
      CKS_DIV2  = 2'b00,
      CKS_DIV4  = 2'b01,
      CKS_DIV8  = 2'b10,
      CKS_DIV16 = 2'b11
   } cks_e;
   localparam int LOAD_BIT   = 7;
   localparam int UPDOWN_BIT = 5;
   localparam int EN_BIT     = 4;
   localparam int CKS_LSB    = 0;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divider that raises tick when the selected low bits of div_cnt are all ones
//   pclk, presetn : clock, async active-low reset
//   en, load      : divider runs only while en=1 and load=0, otherwise held at 0
//   cks           : divide select, /2 /4 /8 /16
//   tick          : combinational, counter steps this cycle
module timer_prescaler #(
   parameter int DIV_W = timer_pkg::DIV_W
) (
   input  logic       pclk,
   input  logic       presetn,
   input  logic       en,
   input  logic       load,
   input  logic [1:0] cks,
   output logic       tick
);
   import timer_pkg::*;
   logic [DIV_W-1:0] div_cnt, mask;
   logic active;
   always_comb begin
      active = en & ~load;
      mask   = ~({DIV_W{1'b1}} << (int'(cks) + 1));
      tick   = active & ((div_cnt & mask) == mask);
   end
   // wraps naturally; never cleared on tick so a cks change takes effect on the next mask match
   always_ff @(posedge pclk or negedge presetn)
      if (!presetn) div_cnt <= '0;
      else          div_cnt <= active ? div_cnt + 1'b1 : '0;
endmodule

// File: rtl/timer_cnt_core.sv
// timer_cnt_core: prescaled 8-bit up/down counter with load and single-cycle wrap flags
//   pclk, presetn : clock, async active-low reset
//   tdr_i, load_i : load value; while load_i=1 the counter tracks tdr_i
//   updown_i      : 1 = down, 0 = up
//   en_i, cks_i   : count enable and prescale select
//   cnt_o         : counter value
//   tick_o        : prescaler tick
//   ovf_o, udf_o  : one-cycle pulses on FF->00 (up) and 00->FF (down)
module timer_cnt_core #(
   parameter int CNT_W = timer_pkg::CNT_W,
   parameter int DIV_W = timer_pkg::DIV_W
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic [CNT_W-1:0] tdr_i,
   input  logic             load_i,
   input  logic             updown_i,
   input  logic             en_i,
   input  logic [1:0]       cks_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tick_o,
   output logic             ovf_o,
   output logic             udf_o
);
   import timer_pkg::*;
   timer_prescaler #(.DIV_W(DIV_W)) u_pre (
      .pclk    (pclk),
      .presetn (presetn),
      .en      (en_i),
      .load    (load_i),
      .cks     (cks_i),
      .tick    (tick_o)
   );
   // flags come from the pre-step value so they cannot be confused by the wrap itself
   always_ff @(posedge pclk or negedge presetn)
      if (!presetn) begin
         cnt_o <= '0;
         ovf_o <= 1'b0;
         udf_o <= 1'b0;
      end else begin
         cnt_o <= load_i ? tdr_i : tick_o ? (updown_i ? cnt_o - 1'b1 : cnt_o + 1'b1) : cnt_o;
         ovf_o <= ~load_i & tick_o & ~updown_i & (cnt_o == '1);
         udf_o <= ~load_i & tick_o & updown_i & (cnt_o == '0);
      end
endmodule

// File: tb/tb_timer_cnt_core.sv
// tb_timer_cnt_core: randomized and directed checks of timer_cnt_core against a behavioural model
module tb_timer_cnt_core;
   logic       pclk = 1'b0;
   logic       presetn;
   logic [7:0] tdr;
   logic       load, updown, en;
   logic [1:0] cks;
   logic [7:0] cnt;
   logic       tick, ovf, udf;
   int n_cmp = 0;
   int n_err = 0;
   int m_cnt, run;
   bit m_ovf, m_udf, e_tick;
   logic o_tick;

   timer_cnt_core dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .tdr_i    (tdr),
      .load_i   (load),
      .updown_i (updown),
      .en_i     (en),
      .cks_i    (cks),
      .cnt_o    (cnt),
      .tick_o   (tick),
      .ovf_o    (ovf),
      .udf_o    (udf)
   );

   always #5 pclk = ~pclk;

   // one pclk of the model: run counts enabled cycles, a step happens when run+1 is a multiple of the divide
   task automatic advance();
      @(negedge pclk);
      e_tick = en && !load && (((run + 1) % (2 << cks)) == 0);
      o_tick = tick;
      @(posedge pclk);
      m_ovf = 0;
      m_udf = 0;
      if (load) m_cnt = int'(tdr);
      else if (e_tick) begin
         if (updown) begin
            m_udf = (m_cnt == 0);
            m_cnt = (m_cnt + 255) % 256;
         end else begin
            m_ovf = (m_cnt == 255);
            m_cnt = (m_cnt + 1) % 256;
         end
      end
      run = (en && !load) ? (run + 1) % 16 : 0;
      #1;
   endtask

   task automatic model_reset();
      m_cnt = 0; run = 0; m_ovf = 0; m_udf = 0;
   endtask

   task automatic load_value(input logic [7:0] v);
      en = 0; load = 1; tdr = v;
      advance();
      load = 0;
   endtask

   task automatic test_reset();
      int bad = 0;
      presetn = 0;
      tdr = 8'($urandom); load = 1'($urandom); updown = 1'($urandom); en = 1'($urandom); cks = 2'($urandom);
      #23;
      model_reset();
      n_cmp++;
      if ({cnt, tick, ovf, udf} !== 11'h0) begin
         n_err++;
         $display("FAIL reset_outputs got cnt=%h tick=%b ovf=%b udf=%b want all 0", cnt, tick, ovf, udf);
      end
      en = 0; load = 0;
      @(negedge pclk) presetn = 1;
      for (int i = 0; i < 20; i++) begin
         tdr = 8'($urandom); cks = 2'($urandom); updown = 1'($urandom);
         advance();
         if (cnt !== 8'h00) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL reset_idle cnt moved %0d times, last %h want 00", bad, cnt);
      end
   endtask

   task automatic test_load();
      load_value(8'h5A);
      n_cmp++;
      if (cnt !== 8'h5A) begin
         n_err++;
         $display("FAIL load_5a got %h want 5a", cnt);
      end
      load = 1; en = 1;
      for (int i = 0; i < 6; i++) begin
         tdr = 8'($urandom);
         advance();
         n_cmp += 2;
         if (o_tick !== 1'b0) begin
            n_err++;
            $display("FAIL load_tick got %b want 0", o_tick);
         end
         if (cnt !== tdr || ovf || udf) begin
            n_err++;
            $display("FAIL load_track got %h ovf=%b udf=%b want %h no flags", cnt, ovf, udf, tdr);
         end
      end
      load = 0; en = 0;
   endtask

   task automatic test_countdown();
      load_value(8'h05);
      updown = 1; cks = 2'b00; en = 1;
      for (int k = 1; k <= 14; k++) begin
         advance();
         n_cmp++;
         if (udf !== (k == 12) || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL cd2_flag k=%0d got udf=%b ovf=%b want udf=%b ovf=0", k, udf, ovf, k == 12);
         end
         if (k == 12) begin
            n_cmp++;
            if (cnt !== 8'hFF) begin
               n_err++;
               $display("FAIL cd2_wrap got %h want ff", cnt);
            end
         end
      end
      en = 0;
   endtask

   task automatic test_pause();
      int bad = 0;
      load_value(8'h20);
      updown = 1; cks = 2'b00; en = 1;
      for (int k = 0; k < 16; k++) advance();
      n_cmp++;
      if (cnt !== 8'h18) begin
         n_err++;
         $display("FAIL pause_value got %h want 18", cnt);
      end
      en = 0;
      for (int k = 0; k < 100; k++) begin
         advance();
         if (cnt !== 8'h18 || udf !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL pause_frozen %0d bad cycles, last cnt=%h udf=%b want 18/0", bad, cnt, udf);
      end
      en = 1;
      for (int k = 1; k <= 52; k++) begin
         advance();
         n_cmp++;
         if (udf !== (k == 50)) begin
            n_err++;
            $display("FAIL pause_resume_udf k=%0d got %b want %b", k, udf, k == 50);
         end
      end
      en = 0;
   endtask

   task automatic test_up16();
      logic [7:0] want;
      load_value(8'hFE);
      updown = 0; cks = 2'b11; en = 1;
      for (int k = 1; k <= 34; k++) begin
         advance();
         want = (k < 16) ? 8'hFE : (k < 32) ? 8'hFF : 8'h00;
         n_cmp += 2;
         if (cnt !== want) begin
            n_err++;
            $display("FAIL up16_cnt k=%0d got %h want %h", k, cnt, want);
         end
         if (ovf !== (k == 32) || udf !== 1'b0) begin
            n_err++;
            $display("FAIL up16_flag k=%0d got ovf=%b udf=%b want ovf=%b udf=0", k, ovf, udf, k == 32);
         end
      end
      en = 0;
   endtask

   task automatic test_sweep();
      for (int it = 0; it < 100; it++) begin
         load_value(8'($urandom_range(1, 255)));
         cks = 2'(it % 4); updown = 1'($urandom); en = 1;
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 39) == 0) cks = 2'($urandom);
            if (m_cnt == 0 && $urandom_range(0, 1) == 1) updown = ~updown;
            if ($urandom_range(0, 99) == 0) en = ~en;
            advance();
            n_cmp += 4;
            if (o_tick !== e_tick) begin
               n_err++;
               $display("FAIL sweep_tick it=%0d c=%0d got %b want %b", it, c, o_tick, e_tick);
            end
            if (cnt !== 8'(m_cnt)) begin
               n_err++;
               $display("FAIL sweep_cnt it=%0d c=%0d got %h want %h", it, c, cnt, 8'(m_cnt));
            end
            if (ovf !== m_ovf) begin
               n_err++;
               $display("FAIL sweep_ovf it=%0d c=%0d got %b want %b", it, c, ovf, m_ovf);
            end
            if (udf !== m_udf) begin
               n_err++;
               $display("FAIL sweep_udf it=%0d c=%0d got %b want %b", it, c, udf, m_udf);
            end
         end
      end
      en = 0;
   endtask

   task automatic test_async_reset();
      load_value(8'h80);
      updown = 0; cks = 2'b00; en = 1;
      for (int k = 0; k < 7; k++) advance();
      #2 presetn = 0;
      #1;
      model_reset();
      n_cmp++;
      if ({cnt, tick, ovf, udf} !== 11'h0) begin
         n_err++;
         $display("FAIL async_reset got cnt=%h tick=%b ovf=%b udf=%b want all 0", cnt, tick, ovf, udf);
      end
      en = 0;
      @(negedge pclk) presetn = 1;
      for (int k = 0; k < 5; k++) advance();
      n_cmp++;
      if (cnt !== 8'h00) begin
         n_err++;
         $display("FAIL async_reset_idle got %h want 00", cnt);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load();
      test_countdown();
      test_pause();
      test_up16();
      test_sweep();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
